// File: rtl/rv_core_pkg.sv
// Core-wide constants shared by the write-back arbiter and the other
// register-file port logic.
package rv_core_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int REG_ZERO = 0;

   // Requester slots on the write-back port.
   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: NUM_REQ requests in, one-hot grant out. The search
// starts at the pointer, and the pointer moves past the winner.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]     ptr_q;
   logic [PTR_W-1:0]     ptr_d;
   logic [2*NUM_REQ-1:0] req_rot;
   logic                 found;
   int                   offset;
   int                   winner;

   // Rotate the requests so the pointer position lands at bit 0.
   // Grants are suppressed while reset is held.
   always_comb begin
      req_rot = {req, req} >> ptr_q;
      found   = 1'b0;
      offset  = 0;
      winner  = 0;
      grant   = '0;
      ptr_d   = ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_rot[k]) begin
            found  = 1'b1;
            offset = k;
         end
      end
      winner = int'(ptr_q) + offset;
      if (winner >= NUM_REQ) begin
         winner = winner - NUM_REQ;
      end
      if (found && reset_n) begin
         grant[PTR_W'(winner)] = 1'b1;
         ptr_d = (winner == NUM_REQ - 1) ? '0 : PTR_W'(winner + 1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the 32x32 register file: round-robin write-back
// arbitration, a registered write stage, and a pending-write scoreboard.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = rv_core_pkg::ADDR_W,
   parameter int DATA_W  = rv_core_pkg::DATA_W
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        issue_valid,
   input  logic [ADDR_W-1:0]           issue_rd,
   output logic                        issue_ready,
   input  logic [ADDR_W-1:0]           rs1,
   input  logic [ADDR_W-1:0]           rs2,
   output logic                        raw_stall,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [rv_core_pkg::NUM_REGS-1:0] busy_vec
);

   localparam int NREGS = rv_core_pkg::NUM_REGS;
   localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(rv_core_pkg::REG_ZERO);

   logic              gnt_any;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_data;

   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic [NREGS-1:0]  busy_q, busy_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req_valid),
      .grant   (req_ready)
   );

   always_comb begin
      gnt_any  = |req_ready;
      gnt_addr = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
            gnt_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Hazard checks look at the pre-edge scoreboard; x0 never stalls.
   always_comb begin
      issue_ready = !busy_q[issue_rd] || (issue_rd == ZERO_REG);
      raw_stall   = ((rs1 != ZERO_REG) && busy_q[rs1]) ||
                    ((rs2 != ZERO_REG) && busy_q[rs2]);
   end

   // A write to x0 is consumed but never reaches the register file.
   // Address/data hold their last values when nothing is granted.
   always_comb begin
      rf_we_d    = gnt_any && (gnt_addr != ZERO_REG);
      rf_waddr_d = gnt_any ? gnt_addr : rf_waddr_q;
      rf_wdata_d = gnt_any ? gnt_data : rf_wdata_q;
      busy_d     = busy_q;
      if (gnt_any) begin
         busy_d[gnt_addr] = 1'b0;
      end
      if (issue_valid && issue_ready && (issue_rd != ZERO_REG)) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign busy_vec = busy_q;

endmodule
